// File: rtl/output_deskew_collector.sv
// Realigns the diagonally skewed outputs of a systolic array into whole rows and
// buffers them in a small FIFO tagged with their row index within the tile.
module output_deskew_collector #(
    parameter int SIZE          = 8,
    parameter int COL           = 8,
    parameter int FIFO_DEPTH    = 4,
    parameter int ROWS_PER_TILE = 32
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               in_valid,
    input  logic [COL*(2*SIZE+1)-1:0]          in_vec,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [COL*(2*SIZE+1)-1:0]          out_vec,
    output logic [$clog2(ROWS_PER_TILE)-1:0]   out_row_idx,
    output logic                               out_last,
    output logic                               overflow
);

    localparam int EW   = 2 * SIZE + 1;
    localparam int ROWW = COL * EW;
    localparam int IW   = $clog2(ROWS_PER_TILE);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;

    wire [ROWW-1:0] w_aligned;

    // Column j arrives j cycles after column 0, so it waits COL-1-j stages;
    // the FIFO write acts as the final capture for every column.
    genvar j;
    for (j = 0; j < COL - 1; j++) begin : g_col
        localparam int D   = COL - 1 - j;
        localparam int LSB = (COL - 1 - j) * EW;
        logic [EW-1:0] r_dly [D];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int k = 0; k < D; k++) r_dly[k] <= '0;
            end else begin
                r_dly[0] <= in_vec[LSB +: EW];
                for (int k = 1; k < D; k++) r_dly[k] <= r_dly[k-1];
            end
        end

        assign w_aligned[LSB +: EW] = r_dly[D-1];
    end
    assign w_aligned[EW-1:0] = in_vec[EW-1:0];

    logic [COL-2:0] r_vpipe;
    logic           w_align_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vpipe <= '0;
        end else begin
            r_vpipe[0] <= in_valid;
            for (int k = 1; k < COL - 1; k++) r_vpipe[k] <= r_vpipe[k-1];
        end
    end
    assign w_align_valid = r_vpipe[COL-2];

    logic [ROWW-1:0] r_mem_vec [FIFO_DEPTH];
    logic [IW-1:0]   r_mem_idx [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [IW-1:0]   r_wr_idx;
    logic            r_overflow;
    logic            w_empty;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;

    // Handshake: a row is transferred in any cycle where out_valid && out_ready;
    // out_valid never depends on out_ready and the head is held until transfer.
    // The array side has no backpressure, so a full FIFO without a pop drops the row.
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(FIFO_DEPTH));
    assign w_pop   = !w_empty && out_ready;
    assign w_push  = w_align_valid && (!w_full || w_pop);
    assign w_drop  = w_align_valid && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_vec[r_wr_ptr] <= w_aligned;
            r_mem_idx[r_wr_ptr] <= r_wr_idx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_wr_idx   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            // Dropped rows still consume an index so the tile numbering stays intact.
            if (w_align_valid) begin
                if (r_wr_idx == IW'(ROWS_PER_TILE - 1)) r_wr_idx <= '0;
                else                                     r_wr_idx <= r_wr_idx + IW'(1);
            end
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    assign out_valid   = !w_empty;
    assign out_vec     = out_valid ? r_mem_vec[r_rd_ptr] : '0;
    assign out_row_idx = out_valid ? r_mem_idx[r_rd_ptr] : '0;
    assign out_last    = out_valid && (r_mem_idx[r_rd_ptr] == IW'(ROWS_PER_TILE - 1));
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_output_deskew_collector.sv
// Randomised bench for output_deskew_collector with a queue-level reference model
// of skewed arrival, alignment latency, tile indexing and FIFO drop behaviour.
module tb_output_deskew_collector;

    localparam int SIZE          = 8;
    localparam int COL           = 8;
    localparam int FIFO_DEPTH    = 4;
    localparam int ROWS_PER_TILE = 32;
    localparam int EW            = 2 * SIZE + 1;
    localparam int ROWW          = COL * EW;
    localparam int IW            = $clog2(ROWS_PER_TILE);

    logic            clk;
    logic            reset;
    logic            in_valid;
    logic [ROWW-1:0] in_vec;
    logic            out_valid;
    logic            out_ready;
    logic [ROWW-1:0] out_vec;
    logic [IW-1:0]   out_row_idx;
    logic            out_last;
    logic            overflow;

    output_deskew_collector #(
        .SIZE          (SIZE),
        .COL           (COL),
        .FIFO_DEPTH    (FIFO_DEPTH),
        .ROWS_PER_TILE (ROWS_PER_TILE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_vec      (in_vec),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_vec     (out_vec),
        .out_row_idx (out_row_idx),
        .out_last    (out_last),
        .overflow    (overflow)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model: rows keyed by the cycle their column 0 was driven,
    // an expected FIFO queue {idx, row}, the tile row counter and sticky overflow.
    logic [ROWW-1:0]    rows_by_start [int];
    logic [IW+ROWW-1:0] exp_q [$];
    int                 model_idx = 0;
    logic               model_ovf = 1'b0;

    logic            last_valid;
    logic [ROWW-1:0] last_vec;
    logic [IW-1:0]   last_idx;
    logic            last_last;
    logic            last_ovf;

    task automatic apply_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_vec    = '0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_valid got=%0b exp=0", out_valid);
        end
        n_checks++;
        if (out_vec !== '0) begin
            n_errors++;
            $display("FAIL reset_vec got=%h exp=0", out_vec);
        end
        n_checks++;
        if (out_row_idx !== '0 || out_last !== 1'b0 || overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_misc idx=%0d last=%0b ovf=%0b exp=0/0/0", out_row_idx, out_last, overflow);
        end
        exp_q.delete();
        rows_by_start.delete();
        model_idx = 0;
        model_ovf = 1'b0;
        repeat (2) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        reset = 1'b0;
    endtask

    // Driver + scoreboard for one clock cycle; called at posedge+1.
    task automatic drive_cycle(input logic v, input logic rdy, input logic use_row,
                               input logic [ROWW-1:0] row);
        logic [ROWW-1:0]    new_row;
        logic [ROWW-1:0]    vec;
        logic [ROWW-1:0]    tmp;
        logic [IW+ROWW-1:0] head;
        logic               exp_v;
        if (use_row) begin
            new_row = row;
        end else begin
            for (int j = 0; j < COL; j++) new_row[j*EW +: EW] = EW'($urandom);
        end
        if (v) rows_by_start[cyc] = new_row;
        for (int j = 0; j < COL; j++) begin
            if (rows_by_start.exists(cyc - j)) begin
                tmp = rows_by_start[cyc - j];
                vec[(COL-1-j)*EW +: EW] = tmp[(COL-1-j)*EW +: EW];
            end else begin
                vec[(COL-1-j)*EW +: EW] = EW'($urandom);
            end
        end
        in_valid  = v;
        in_vec    = vec;
        out_ready = rdy;
        #1;
        exp_v = (exp_q.size() > 0);
        head  = exp_v ? exp_q[0] : '0;
        n_checks++;
        if (out_valid !== exp_v) begin
            n_errors++;
            $display("FAIL sb_valid cyc=%0d got=%0b exp=%0b", cyc, out_valid, exp_v);
        end else if (exp_v) begin
            n_checks++;
            if (out_vec !== head[ROWW-1:0]) begin
                n_errors++;
                $display("FAIL sb_vec cyc=%0d got=%h exp=%h", cyc, out_vec, head[ROWW-1:0]);
            end
            n_checks++;
            if (out_row_idx !== head[IW+ROWW-1:ROWW]) begin
                n_errors++;
                $display("FAIL sb_idx cyc=%0d got=%0d exp=%0d", cyc, out_row_idx, head[IW+ROWW-1:ROWW]);
            end
        end
        n_checks++;
        if (out_last !== (exp_v && (head[IW+ROWW-1:ROWW] == IW'(ROWS_PER_TILE - 1)))) begin
            n_errors++;
            $display("FAIL sb_last cyc=%0d got=%0b", cyc, out_last);
        end
        n_checks++;
        if (overflow !== model_ovf) begin
            n_errors++;
            $display("FAIL sb_ovf cyc=%0d got=%0b exp=%0b", cyc, overflow, model_ovf);
        end
        last_valid = out_valid;
        last_vec   = out_vec;
        last_idx   = out_row_idx;
        last_last  = out_last;
        last_ovf   = overflow;
        // Model update for this clock edge: pop first, then the aligned push.
        if (exp_v && rdy) void'(exp_q.pop_front());
        if (rows_by_start.exists(cyc - (COL - 1))) begin
            if (exp_q.size() == FIFO_DEPTH) model_ovf = 1'b1;
            else exp_q.push_back({IW'(model_idx), rows_by_start[cyc - (COL - 1)]});
            model_idx = (model_idx + 1) % ROWS_PER_TILE;
            rows_by_start.delete(cyc - (COL - 1));
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        drive_cycle(1'b0, 1'b1, 1'b0, '0);
    endtask

    task automatic test_single_row();
        logic [ROWW-1:0] row;
        logic [ROWW-1:0] hit_vec;
        logic [IW-1:0]   hit_idx;
        int              hits;
        int              hit_k;
        apply_reset();
        for (int j = 0; j < COL; j++) row[(COL-1-j)*EW +: EW] = EW'(j + 1);
        hits = 0;
        hit_k = -1;
        hit_vec = '0;
        hit_idx = '1;
        for (int k = 0; k < 14; k++) begin
            drive_cycle(k == 0, 1'b1, 1'b1, row);
            if (last_valid) begin
                hits++;
                hit_k = k;
                hit_vec = last_vec;
                hit_idx = last_idx;
            end
        end
        n_checks++;
        if (hits != 1 || hit_k != COL) begin
            n_errors++;
            $display("FAIL single_latency hits=%0d at=%0d exp=1 at %0d", hits, hit_k, COL);
        end
        n_checks++;
        if (hit_vec !== row || hit_idx !== '0) begin
            n_errors++;
            $display("FAIL single_row got=%h idx=%0d exp=%h idx=0", hit_vec, hit_idx, row);
        end
    endtask

    task automatic test_tile_wrap();
        int n_out;
        int n_last;
        apply_reset();
        n_out = 0;
        n_last = 0;
        for (int k = 0; k < ROWS_PER_TILE + 1 + 12; k++) begin
            drive_cycle(k <= ROWS_PER_TILE, 1'b1, 1'b0, '0);
            if (last_valid) begin
                n_checks++;
                if (last_idx !== IW'(n_out % ROWS_PER_TILE)) begin
                    n_errors++;
                    $display("FAIL tile_idx got=%0d exp=%0d", last_idx, n_out % ROWS_PER_TILE);
                end
                if (last_last) n_last++;
                n_out++;
            end
        end
        n_checks++;
        if (n_out != ROWS_PER_TILE + 1 || n_last != 1) begin
            n_errors++;
            $display("FAIL tile_count outs=%0d lasts=%0d exp=%0d/1", n_out, n_last, ROWS_PER_TILE + 1);
        end
    endtask

    task automatic test_overflow();
        int got_idx [$];
        int first_idx;
        apply_reset();
        for (int k = 0; k < 15; k++) drive_cycle(k < 5, 1'b0, 1'b0, '0);
        n_checks++;
        if (last_ovf !== 1'b1) begin
            n_errors++;
            $display("FAIL ovf_set got=%0b exp=1", last_ovf);
        end
        for (int k = 0; k < 8; k++) begin
            drive_cycle(1'b0, 1'b1, 1'b0, '0);
            if (last_valid) got_idx.push_back(int'(last_idx));
        end
        n_checks++;
        if (got_idx.size() != 4 || got_idx[0] != 0 || got_idx[1] != 1 || got_idx[2] != 2 || got_idx[3] != 3) begin
            n_errors++;
            $display("FAIL ovf_drain got_count=%0d exp=4 rows 0..3", got_idx.size());
        end
        first_idx = -1;
        for (int k = 0; k < 12; k++) begin
            drive_cycle(k == 0, 1'b1, 1'b0, '0);
            if (last_valid && first_idx < 0) first_idx = int'(last_idx);
        end
        n_checks++;
        if (first_idx != 5 || last_ovf !== 1'b1) begin
            n_errors++;
            $display("FAIL ovf_next idx=%0d ovf=%0b exp=5/1", first_idx, last_ovf);
        end
    endtask

    task automatic test_full_push_pop();
        int got_idx [$];
        int ok;
        apply_reset();
        for (int k = 0; k < 26; k++) begin
            drive_cycle(k < 5, k >= 11, 1'b0, '0);
            if (last_valid && k >= 11) got_idx.push_back(int'(last_idx));
        end
        ok = (got_idx.size() == 5);
        for (int i = 0; i < got_idx.size(); i++) if (got_idx[i] != i) ok = 0;
        n_checks++;
        if (ok == 0 || last_ovf !== 1'b0) begin
            n_errors++;
            $display("FAIL full_pushpop rows=%0d ovf=%0b exp=5/0", got_idx.size(), last_ovf);
        end
    endtask

    task automatic test_toggle_ready();
        logic            prev_stall;
        logic [ROWW-1:0] prev_vec;
        logic [IW-1:0]   prev_idx;
        int              prev_out;
        logic            rdy;
        apply_reset();
        prev_stall = 1'b0;
        prev_vec = '0;
        prev_idx = '0;
        prev_out = -1;
        for (int k = 0; k < 44; k++) begin
            rdy = (k >= 24) || (k % 2 == 0);
            drive_cycle(k < 24, rdy, 1'b0, '0);
            if (prev_stall) begin
                n_checks++;
                if (last_valid !== 1'b1 || last_vec !== prev_vec || last_idx !== prev_idx) begin
                    n_errors++;
                    $display("FAIL stall_stable got=%h/%0d exp=%h/%0d", last_vec, last_idx, prev_vec, prev_idx);
                end
            end
            if (last_valid && rdy) begin
                n_checks++;
                if (int'(last_idx) <= prev_out) begin
                    n_errors++;
                    $display("FAIL order got=%0d after=%0d", last_idx, prev_out);
                end
                prev_out = int'(last_idx);
            end
            prev_stall = last_valid && !rdy;
            prev_vec = last_vec;
            prev_idx = last_idx;
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int k = 0; k < 400; k++)
            drive_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, 1'b0, '0);
        for (int k = 0; k < 20; k++) drive_cycle(1'b0, 1'b1, 1'b0, '0);
    endtask

    task automatic test_reset_mid();
        int hits;
        int first_idx;
        apply_reset();
        for (int k = 0; k < 14; k++) drive_cycle(k < 3 || k == 10 || k == 11, 1'b0, 1'b0, '0);
        n_checks++;
        if (last_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_prefill got=%0b exp=1", last_valid);
        end
        apply_reset();
        hits = 0;
        for (int k = 0; k < 15; k++) begin
            drive_cycle(1'b0, 1'b1, 1'b0, '0);
            if (last_valid) hits++;
        end
        n_checks++;
        if (hits != 0) begin
            n_errors++;
            $display("FAIL mid_stale got=%0d rows exp=0", hits);
        end
        first_idx = -1;
        for (int k = 0; k < 12; k++) begin
            drive_cycle(k == 0, 1'b1, 1'b0, '0);
            if (last_valid && first_idx < 0) first_idx = int'(last_idx);
        end
        n_checks++;
        if (first_idx != 0) begin
            n_errors++;
            $display("FAIL mid_next_idx got=%0d exp=0", first_idx);
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_vec    = '0;
        test_reset();
        test_single_row();
        test_tile_wrap();
        test_overflow();
        test_full_push_pop();
        test_toggle_ready();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/output_deskew_collector.md
OUTPUT_DESKEW_COLLECTOR -- requirements
Module: output_deskew_collector

Interface
- REQ-001: Parameter SIZE, default 8, operand width; result element width is 2*SIZE+1.
- REQ-002: Parameter COL, default 8, number of array output columns.
- REQ-003: Parameter FIFO_DEPTH, default 4, aligned-row buffer entries (power of 2, >=2).
- REQ-004: Parameter ROWS_PER_TILE, default 32, rows per tile before the row index wraps.
- REQ-005: clk  input  1  single clock; all state updates on rising edge.
- REQ-006: reset  input  1  asynchronous, active-high; clears all state immediately.
- REQ-007: in_valid  input  1  column 0 of in_vec holds element 0 of a new row this cycle.
- REQ-008: in_vec  input  COL*(2*SIZE+1)  skewed array outputs, column 0 in MSBs; column j carries a row's element j cycles after column 0.
- REQ-009: out_valid  output  1  an aligned row is presented on out_vec.
- REQ-010: out_ready  input  1  consumer accepts the row when out_valid && out_ready.
- REQ-011: out_vec  output  COL*(2*SIZE+1)  de-skewed row, column 0 in MSBs.
- REQ-012: out_row_idx  output  $clog2(ROWS_PER_TILE)  tile row index of the presented row.
- REQ-013: out_last  output  1  high while the presented row has index ROWS_PER_TILE-1.
- REQ-014: overflow  output  1  sticky: an aligned row was dropped because the FIFO was full.

Function
- REQ-015: Column j shall pass through a register delay of COL-1-j stages (column COL-1 none beyond capture), so all elements of one row align in the same cycle.
- REQ-016: in_valid shall be delayed COL-1 cycles to form an internal align_valid pulse coincident with the aligned row.
- REQ-017: Delay-line registers shall shift every cycle regardless of in_valid or out_ready; no backpressure to the array.
- REQ-018: On align_valid, the aligned row and the current write-side row index shall be pushed into the FIFO.
- REQ-019: Latency: in_valid in cycle t with empty FIFO shall produce out_valid in cycle t+COL (cycle 8 for COL=8).
- REQ-020: Write-side row index shall increment on every align_valid, including dropped rows, and wrap from ROWS_PER_TILE-1 to 0.
- REQ-021: out_valid shall equal FIFO non-empty; out_vec/out_row_idx shall be the head entry and stay stable while out_valid && !out_ready.
- REQ-022: Pop on out_valid && out_ready; head advances next cycle.
- REQ-023: Push when full and no pop in the same cycle: row dropped, FIFO unchanged, overflow set and held until reset.
- REQ-024: Push and pop in the same cycle when full: both succeed, no overflow.
- REQ-025: Push and pop in the same cycle when empty: row not bypassed; appears next cycle.
- REQ-026: FIFO pointers shall wrap modulo FIFO_DEPTH; occupancy never exceeds FIFO_DEPTH.
- REQ-027: Back-to-back in_valid on consecutive cycles shall yield consecutive aligned rows with no loss while out_ready=1.
- REQ-028: Arithmetic is pass-through only; element values are not modified, sign-extended or truncated.

Reset
- REQ-029: Reset shall clear delay lines, valid pipeline, FIFO pointers, row index and overflow to 0.
- REQ-030: During and after reset: out_valid=0, out_vec=0, out_row_idx=0, out_last=0, overflow=0.
- REQ-031: Reset mid-operation shall discard all rows in flight and buffered; the first row after release has index 0.

Verification
- REQ-032: Single row, COL=8, column j element = j+1 arriving at cycle j, in_valid at cycle 0, out_ready=1 -> out_valid only in cycle 8, out_vec columns 1..8, out_row_idx=0.
- REQ-033: 32 back-to-back rows, out_ready=1 -> 32 consecutive outputs, indices 0..31, out_last only on index 31, next tile starts at 0.
- REQ-034: out_ready=0, 5 rows with FIFO_DEPTH=4 -> rows 0-3 held, row 4 dropped, overflow=1; drain yields indices 0,1,2,3; next row has index 5.
- REQ-035: FIFO full, out_ready=1 in the push cycle -> no drop, overflow stays 0, order preserved.
- REQ-036: out_ready toggling 1/0 per cycle under continuous input with depth 4 -> out_vec stable while stalled, no reordering.
- REQ-037: reset pulsed with 3 rows buffered and 2 in delay lines -> out_valid=0 immediately; no stale row emitted; next row index 0.
